// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: two-channel binary-to-BCD converter sharing one iterative double-dabble engine
module bcd_conv_sched #(
  parameter bit SAT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_a,
  input  logic [9:0]  val_a,
  input  logic        req_b,
  input  logic [9:0]  val_b,
  output logic        ack_a,
  output logic        ack_b,
  output logic [11:0] dig_a,
  output logic [11:0] dig_b,
  output logic        ovf_a,
  output logic        ovf_b,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t state, state_nx;
  logic [25:0] sr, sr_adj;
  logic [3:0] cnt;
  logic sel, elig_a, elig_b, grant, grant_b, wr_a, wr_b, ovf;
  logic [11:0] res;
  // a channel whose ack is showing this cycle was just served on this same request level
  assign elig_a = req_a & ~ack_a;
  assign elig_b = req_b & ~ack_b;
  // sel holds the last granted channel (1 = B); B wins a tie only when A was served last
  assign grant_b = elig_b & (~elig_a | ~sel);
  // the thousands digit never reaches 5, so it needs no correction but still flags overflow
  for (genvar n = 0; n < 4; n++) begin : g_adj
    assign sr_adj[10+4*n +: 4] = sr[10+4*n +: 4] >= 4'd5 ? sr[10+4*n +: 4] + 4'd3 : sr[10+4*n +: 4];
  end
  assign sr_adj[9:0] = sr[9:0];
  assign ovf = |sr[25:22];
  assign res = (SAT_EN && ovf) ? 12'h999 : sr[21:10];
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  // next-state logic: ten iterations in CONV, then one write cycle in DONE
  always_comb
    state_nx = state == IDLE ? ((elig_a | elig_b) ? CONV : IDLE) :
               state == CONV ? (cnt == 4'd9 ? DONE : CONV) : IDLE;
  // output decode
  always_comb begin
    busy  = state != IDLE;
    grant = state == IDLE && (elig_a || elig_b);
    wr_a  = state == DONE && !sel;
    wr_b  = state == DONE && sel;
  end
  // converter datapath: load on grant, one adjust-and-shift per CONV cycle
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sr  <= '0;
      cnt <= '0;
      sel <= 1'b1;
    end else if (grant) begin
      sr  <= {16'd0, grant_b ? val_b : val_a};
      cnt <= '0;
      sel <= grant_b;
    end else if (state == CONV) begin
      sr  <= {sr_adj[24:0], 1'b0};
      cnt <= cnt + 4'd1;
    end
  // result registers and one-cycle acknowledge pulses
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      dig_a <= '0;
      dig_b <= '0;
      ovf_a <= 1'b0;
      ovf_b <= 1'b0;
    end else begin
      ack_a <= wr_a;
      ack_b <= wr_b;
      if (wr_a) begin
        dig_a <= res;
        ovf_a <= ovf;
      end
      if (wr_b) begin
        dig_b <= res;
        ovf_b <= ovf;
      end
    end
endmodule

// File: doc/bcd_conv_sched.md
BCD_CONV_SCHED -- requirements
Module: bcd_conv_sched

Interface
REQ-001 Parameter: SAT_EN, default 1, 1 = inputs above 999 saturate to 999; 0 = thousands digit dropped (value mod 1000).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 req_a  input  1  channel A (oven temperature) conversion request, level.
REQ-005 val_a  input  10  channel A unsigned binary value; held stable while req_a high.
REQ-006 req_b  input  1  channel B (setpoint) conversion request, level.
REQ-007 val_b  input  10  channel B unsigned binary value; held stable while req_b high.
REQ-008 ack_a  output  1  one-cycle pulse; dig_a/ovf_a updated.
REQ-009 ack_b  output  1  one-cycle pulse; dig_b/ovf_b updated.
REQ-010 dig_a  output  12  channel A BCD result: [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-011 dig_b  output  12  channel B BCD result, same layout.
REQ-012 ovf_a  output  1  last channel A value exceeded 999.
REQ-013 ovf_b  output  1  last channel B value exceeded 999.
REQ-014 busy  output  1  high in every non-IDLE state.

Function
REQ-015 The block SHALL share one iterative shift-and-add-3 (double-dabble) converter between channels A and B.
REQ-016 FSM states SHALL be IDLE, CONV, DONE.
REQ-017 IDLE: on an edge with any eligible request, SHALL grant one channel, capture its value into the shift register, clear iteration counter, go to CONV.
REQ-018 Arbitration SHALL be round-robin: single request wins; both requesting -> channel not served last; after reset "last served" = B, so A wins first tie.
REQ-019 CONV: each edge SHALL do one iteration (add 3 to each BCD nibble >= 5, then shift left 1), counter +1; the edge completing iteration 10 SHALL go to DONE.
REQ-020 DONE: next edge SHALL write the granted channel's dig/ovf registers, pulse its ack high for exactly one cycle, return to IDLE.
REQ-021 Latency: grant edge to the edge raising ack SHALL be exactly 11 clocks; back-to-back conversions SHALL start no faster than every 12 clocks.
REQ-022 While ack_x is high, req_x SHALL be ineligible that cycle (no repeat grant of the same sampled request); if req_x is still high the following cycle, it is a new request.
REQ-023 A request arriving while busy SHALL be held pending (level) and arbitrated at the next IDLE cycle; requests are never lost while req stays high.
REQ-024 Value > 999: ovf_x SHALL be set with ack_x; with SAT_EN=1 dig_x = 12'h999; with SAT_EN=0 dig_x = low three BCD digits (1023 -> 12'h023).
REQ-025 Value <= 999: ovf_x SHALL be cleared with ack_x; dig_x = exact BCD.
REQ-026 Channel outputs not being acknowledged SHALL hold their values.
REQ-027 ack_a and ack_b SHALL never be high in the same cycle.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, dig_a = dig_b = 0, ovf_a = ovf_b = 0, ack_a = ack_b = 0, busy = 0, last served = B, counter = 0.
REQ-029 Reset mid-conversion SHALL abort without any ack; after release a held request SHALL be granted on the first edge.

Verification
REQ-030 Reset, no requests -> all outputs 0 indefinitely; busy 0.
REQ-031 req_a, val_a=317 -> busy high from grant edge, ack_a exactly 11 clocks after grant, dig_a=12'h317, ovf_a=0, dig_b unchanged.
REQ-032 After reset, req_a (val 5) and req_b (val 999) raised same cycle, dropped on respective ack -> ack_a at grant+11 with dig_a=12'h005; ack_b 12 clocks later with dig_b=12'h999; never simultaneous.
REQ-033 val_a=1023 with SAT_EN=1 -> dig_a=12'h999, ovf_a=1; SAT_EN=0 -> dig_a=12'h023, ovf_a=1; next val_a=0 -> dig_a=12'h000, ovf_a=0.
REQ-034 reset_n pulsed low during 5th CONV cycle -> no ack, outputs 0 at once; req_b held through release -> ack_b 11 clocks after first post-reset edge.
REQ-035 req_a and req_b held high continuously -> acks alternate A, B, A, B every 12 clocks; each result matches its value.
